axi_lite_req_arbiter: RTL
=========================

AXI_LITE_REQ_ARBITER -- requirements
Module: axi_lite_req_arbiter

Interface
REQ-001 Parameters SHALL be: REQ_NUM, default 4, number of requesters; C_M_AXI_DATA_WIDTH, default 32, data width; C_M_AXI_ADDR_WIDTH, default 8, address width.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- M_AXI_ACLK, in, 1, clock
- M_AXI_ARESET, in, 1, async active-high reset
- req_valid, in, REQ_NUM, per-requester request
- req_wr, in, REQ_NUM, 1=write, 0=read
- req_addr, in, REQ_NUM*AW, packed addresses
- req_wdata, in, REQ_NUM*DW, packed write data
- req_ready, out, REQ_NUM, one-hot accept pulse
- rsp_valid, out, REQ_NUM, one-hot completion pulse
- rsp_rdata, out, DW, read data, shared
- rsp_err, out, 1, 1 when the response was not OKAY
- M_AXI_AW*/W*/B*/AR*/R*, master side, full AXI-lite set (AWADDR, AWPROT, AWVALID, AWREADY, WDATA, WSTRB, WVALID, WREADY, BRESP, BVALID, BREADY, ARADDR, ARPROT, ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY)

Function
REQ-004 The FSM SHALL have these states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE; only one AXI transaction SHALL be outstanding at a time.
REQ-005 IDLE: when any req_valid bit is set, the block SHALL grant round-robin, searching from pointer rr_ptr upward with wrap. It SHALL pulse req_ready[winner] for one cycle in that cycle and capture wr, addr and wdata.
REQ-006 After a grant, rr_ptr SHALL become (winner+1) mod REQ_NUM. rr_ptr SHALL reset to 0.
REQ-007 A write grant SHALL go to WR_ADDR, where AWVALID and WVALID are both asserted in the next cycle. Each SHALL deassert independently on its own handshake. The FSM SHALL go to WR_RESP after both handshakes, in any order or in the same cycle.
REQ-008 WR_RESP SHALL hold BREADY=1. On BVALID it SHALL latch rsp_err=(BRESP!=0) and go to DONE.
REQ-009 A read grant SHALL go to RD_ADDR, holding ARVALID until ARREADY and then going to RD_DATA. RD_DATA SHALL hold RREADY=1. On RVALID it SHALL latch RDATA into rsp_rdata, set rsp_err=(RRESP!=0) and go to DONE.
REQ-010 DONE SHALL pulse rsp_valid[winner] for one cycle, then return to IDLE. The earliest next grant SHALL be the cycle after DONE.
REQ-011 AWPROT and ARPROT SHALL be 3'b000. WSTRB SHALL be all ones.
REQ-012 AW/W/AR VALID, ADDR and DATA SHALL stay stable until their handshake. VALID SHALL never depend combinationally on READY.
REQ-013 rsp_rdata SHALL hold its value until the next read completes. rsp_err SHALL be valid only while any rsp_valid bit is set.
REQ-014 A requester deasserting req_valid before its grant SHALL be a legal withdrawal. A request arriving mid-transaction SHALL wait until IDLE.
REQ-015 With REQ_NUM=1 the pointer SHALL stay at 0.

Reset
REQ-016 Reset SHALL give: state IDLE; all VALID/READY outputs 0; req_ready=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; AWADDR/ARADDR/WDATA=0.
REQ-017 Reset asserted mid-transaction SHALL abort it immediately. No rsp_valid SHALL be issued for the aborted request.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding and the OKAY response constant 2'b00.
REQ-019 The round-robin grant logic SHALL be one sub-module, rr_arbiter: inputs req vector and pointer; output one-hot grant plus index.

Verification
REQ-020 Single write: req_valid=0001, wr=1, addr=0x04, wdata=0xDEADBEEF, slave answers OKAY -> AWADDR=0x04, WDATA=0xDEADBEEF; rsp_valid=0001, rsp_err=0.
REQ-021 Read-back: read of addr 0x04 after REQ-020 -> rsp_rdata=0xDEADBEEF, rsp_valid=0001.
REQ-022 Fairness: req_valid=1111 held continuously -> grants in order 0,1,2,3,0 with no requester granted twice before the others.
REQ-023 Skewed handshake: AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 beat, AWVALID holds 3 cycles, and exactly one B is accepted.
REQ-024 Error response: RRESP=2'b10 on a read of addr 0xFC -> rsp_err=1 with rsp_valid.
REQ-025 Mid-transaction reset: reset asserted in WR_RESP -> all outputs return to their reset values in the same cycle, no rsp_valid, and rr_ptr=0.

Source files
------------

// File: rtl/axi_lite_req_arbiter_pkg.sv
// Shared types for the AXI-lite request arbiter: FSM state encoding, response codes
// and a helper that sizes requester index fields.
package axi_lite_req_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
// Zero latency; gnt_o is all-zero when nothing requests.
module rr_arbiter
    import axi_lite_req_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    localparam int IW1 = IW + 1;

    logic [IW1-1:0] sum;
    logic [IW-1:0]  cand;
    logic           found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        sum   = '0;
        cand  = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr_i} + IW1'(off);
            if (sum >= IW1'(N)) begin
                sum = sum - IW1'(N);
            end
            cand = sum[IW-1:0];
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter funnelling N requesters onto one AXI-lite master, one transaction at a time.
// req_ready pulses in the grant cycle; rsp_valid pulses one cycle after the B/R handshake.
module axi_lite_req_arbiter
    import axi_lite_req_arbiter_pkg::*;
#(
    parameter int REQ_NUM            = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 8
) (
    input  logic                                     M_AXI_ACLK,
    input  logic                                     M_AXI_ARESET,
    input  logic [REQ_NUM-1:0]                       req_valid,
    input  logic [REQ_NUM-1:0]                       req_wr,
    input  logic [REQ_NUM*C_M_AXI_ADDR_WIDTH-1:0]    req_addr,
    input  logic [REQ_NUM*C_M_AXI_DATA_WIDTH-1:0]    req_wdata,
    output logic [REQ_NUM-1:0]                       req_ready,
    output logic [REQ_NUM-1:0]                       rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]            rsp_rdata,
    output logic                                     rsp_err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]            M_AXI_AWADDR,
    output logic [2:0]                               M_AXI_AWPROT,
    output logic                                     M_AXI_AWVALID,
    input  logic                                     M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]            M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]          M_AXI_WSTRB,
    output logic                                     M_AXI_WVALID,
    input  logic                                     M_AXI_WREADY,
    input  logic [1:0]                               M_AXI_BRESP,
    input  logic                                     M_AXI_BVALID,
    output logic                                     M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]            M_AXI_ARADDR,
    output logic [2:0]                               M_AXI_ARPROT,
    output logic                                     M_AXI_ARVALID,
    input  logic                                     M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]            M_AXI_RDATA,
    input  logic [1:0]                               M_AXI_RRESP,
    input  logic                                     M_AXI_RVALID,
    output logic                                     M_AXI_RREADY
);

    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int IW = idx_width(REQ_NUM);

    state_e               state_q;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [REQ_NUM-1:0]   win_oh_q, rsp_valid_q;
    logic                 awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, err_q;
    logic [AW-1:0]        awaddr_q, araddr_q;
    logic [DW-1:0]        wdata_q, rdata_q;

    logic [REQ_NUM-1:0]   gnt;
    logic [IW-1:0]        gnt_idx;
    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_wdata;
    logic                 aw_done, w_done;

    rr_arbiter #(.N(REQ_NUM), .IW(IW)) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign sel_addr  = req_addr[int'(gnt_idx)*AW +: AW];
    assign sel_wdata = req_wdata[int'(gnt_idx)*DW +: DW];
    assign rr_ptr_d  = (int'(gnt_idx) == REQ_NUM - 1) ? '0 : gnt_idx + 1'b1;

    // A channel counts as done once it has already handshaken or does so this cycle.
    assign aw_done = !awvalid_q || M_AXI_AWREADY;
    assign w_done  = !wvalid_q  || M_AXI_WREADY;

    // Grant is accepted combinationally so the requester sees ready in its request cycle.
    assign req_ready = (state_q == ST_IDLE && !M_AXI_ARESET) ? gnt : '0;

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            win_oh_q    <= '0;
            rsp_valid_q <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            err_q       <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        win_oh_q <= gnt;
                        rr_ptr_q <= rr_ptr_d;
                        if (req_wr[gnt_idx]) begin
                            awaddr_q  <= sel_addr;
                            wdata_q   <= sel_wdata;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WR_ADDR;
                        end else begin
                            araddr_q  <= sel_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_ADDR: begin
                    if (M_AXI_AWREADY) awvalid_q <= 1'b0;
                    if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        bready_q    <= 1'b0;
                        err_q       <= (M_AXI_BRESP != RESP_OKAY);
                        rsp_valid_q <= win_oh_q;
                        state_q     <= ST_DONE;
                    end
                end
                ST_RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        rready_q    <= 1'b0;
                        rdata_q     <= M_AXI_RDATA;
                        err_q       <= (M_AXI_RRESP != RESP_OKAY);
                        rsp_valid_q <= win_oh_q;
                        state_q     <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
